mem_access_unit: RTL and testbench

Multi-cycle memory access unit between the control decoder and the external single-port memory bus. Converts the decoder's level-held `ReadReq`/`WenMem` requests and `MemStrb` (RISC-V funct3) width code into one bus transaction with byte enables. Returns lane-extracted, sign/zero-extended read data with a one-cycle `DataValid` pulse. Serves instruction fetch, loads, stores, AMO read/write halves and ECALL vector reads.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_lane_format.sv | 65 ++++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared width codes (RISC-V funct3) and FSM state encoding for the memory access unit.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    REL  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// External single-port memory bus; the access unit is the master, the memory the slave.
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_lane_format.sv
// Combinational lane formatting: byte enables, store replication, load extraction/extension.
// The misaligned output only exists when MEM_MISALIGN_CHK_EN is defined.
module mem_lane_format
  import mem_pkg::*;
(
  input  logic [2:0]  strb,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        legal
`ifdef MEM_MISALIGN_CHK_EN
  , output logic      misaligned
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lanes ignore offset[0], which is how misaligned halves get forced aligned.
  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    legal     = 1'b1;
    case (strb)
      MEM_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_BU: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'd0, byte_sel};
      end
      MEM_H: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
      end
      MEM_HU: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'd0, half_sel};
      end
      MEM_W: begin
        be        = 4'b1111;
        rdata_ext = rdata;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misaligned = (((strb == MEM_H) || (strb == MEM_HU)) && offset[0]) ||
                      ((strb == MEM_W) && (offset != 2'b00));
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: turns held decoder requests into one bus transaction.
// Optional misalignment trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadReq,
  input  logic        WenMem,
  input  logic [2:0]  MemStrb,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        DataValid,
  output logic        MisAlign,
  mem_access_unit_if.master bus
);

  state_t      state;
  logic        we_q;
  logic [2:0]  strb_q;
  logic [1:0]  off_q;

  logic [2:0]  fmt_strb;
  logic [1:0]  fmt_off;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;
  logic        fmt_legal;
  logic        skip_bus;
  logic        new_req;

  // In IDLE the formatter sees the live request; afterwards it uses the latched width/offset.
  assign fmt_strb = (state == IDLE) ? MemStrb : strb_q;
  assign fmt_off  = (state == IDLE) ? Addr[1:0] : off_q;
  assign new_req  = WenMem || ReadReq;

`ifdef MEM_MISALIGN_CHK_EN
  logic fmt_misaligned;

  mem_lane_format u_fmt (
    .strb       (fmt_strb),
    .offset     (fmt_off),
    .wdata      (WrData),
    .rdata      (bus.bus_rdata),
    .be         (fmt_be),
    .wdata_rep  (fmt_wdata),
    .rdata_ext  (fmt_rdata),
    .legal      (fmt_legal),
    .misaligned (fmt_misaligned)
  );

  assign skip_bus = !fmt_legal || fmt_misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      MisAlign <= 1'b0;
    else if (state == IDLE && new_req && fmt_misaligned)
      MisAlign <= 1'b1;
    else if (state == REL)
      MisAlign <= 1'b0;
  end
`else
  mem_lane_format u_fmt (
    .strb      (fmt_strb),
    .offset    (fmt_off),
    .wdata     (WrData),
    .rdata     (bus.bus_rdata),
    .be        (fmt_be),
    .wdata_rep (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .legal     (fmt_legal)
  );

  assign skip_bus = !fmt_legal;
  assign MisAlign = 1'b0;
`endif

  // Request/response FSM; DataValid pulses the cycle after RESP is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      strb_q        <= 3'd0;
      off_q         <= 2'd0;
      RdData        <= 32'd0;
      DataValid     <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      DataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (new_req) begin
            we_q   <= WenMem;
            strb_q <= MemStrb;
            off_q  <= Addr[1:0];
            if (skip_bus) begin
              RdData <= 32'd0;
              state  <= RESP;
            end else begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= WenMem;
              bus.bus_addr  <= {Addr[31:2], 2'b00};
              bus.bus_be    <= fmt_be;
              bus.bus_wdata <= fmt_wdata;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            if (!we_q)
              RdData <= fmt_rdata;
            bus.bus_req <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          DataValid <= 1'b1;
          state     <= REL;
        end
        REL: begin
          // A request still held from this transaction must drop before another can start.
          if (!new_req)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then randomized accesses vs a reference model.
// Expectations follow MEM_MISALIGN_CHK_EN when it is defined for the build.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ReadReq;
  logic        WenMem;
  logic [2:0]  MemStrb;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        DataValid;
  logic        MisAlign;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ReadReq   (ReadReq),
    .WenMem    (WenMem),
    .MemStrb   (MemStrb),
    .Addr      (Addr),
    .WrData    (WrData),
    .RdData    (RdData),
    .DataValid (DataValid),
    .MisAlign  (MisAlign),
    .bus       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Reference: access size in bytes, natural-aligned offset, mask/shift arithmetic on longints.
  function automatic void refModel(input logic [2:0] strb, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   output bit legal, output bit misal, output logic [3:0] be,
                                   output logic [31:0] wrep, output logic [31:0] rext);
    int     size;
    int     off;
    longint mask;
    longint v;
    longint w;
    legal = 1'b1;
    case (strb)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default: begin legal = 1'b0; size = 1; end
    endcase
    off   = int'(addr % 4);
    misal = legal && (off % size != 0);
    off   = off - (off % size);
    mask  = (64'd1 << (8 * size)) - 1;
    be    = legal ? 4'(((1 << size) - 1) << off) : 4'b0000;
    w     = 0;
    for (int i = 0; i < 4 / size; i++)
      w = w | ((longint'(wdata) & mask) << (8 * size * i));
    wrep  = 32'(w);
    v     = (longint'(rdata) >> (8 * off)) & mask;
    if (strb[2] == 1'b0 && size < 4 && v >= (mask + 1) / 2)
      v = v - (mask + 1);
    rext  = 32'(v);
  endfunction

  // One complete access: request, optional bus wait, DataValid pulse, request held then released.
  task automatic applyStimulus(input bit we, input logic [2:0] strb, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int delay, input int hold);
    bit          legal;
    bit          misal;
    bit          do_bus;
    bit          exp_mis;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rext;
    refModel(strb, addr, wdata, rdata, legal, misal, be, wrep, rext);
    exp_mis = CHK_EN && misal;
    do_bus  = legal && !exp_mis;

    @(negedge clk);
    ReadReq = !we;
    WenMem  = we;
    MemStrb = strb;
    Addr    = addr;
    WrData  = wdata;
    @(posedge clk); #1;
    if (do_bus) begin
      checkOutput("bus_req", 32'(bus.bus_req), 32'd1);
      checkOutput("bus_we", 32'(bus.bus_we), 32'(we));
      checkOutput("bus_addr", bus.bus_addr, {addr[31:2], 2'b00});
      checkOutput("bus_be", 32'(bus.bus_be), 32'(be));
      if (we)
        checkOutput("bus_wdata", bus.bus_wdata, wrep);
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
        checkOutput("req_held", 32'(bus.bus_req), 32'd1);
        checkOutput("dv_wait", 32'(DataValid), 32'd0);
      end
      @(negedge clk);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = rdata;
      @(posedge clk); #1;
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = $urandom;
      checkOutput("req_drop", 32'(bus.bus_req), 32'd0);
      checkOutput("dv_early", 32'(DataValid), 32'd0);
      if (!we)
        exp_rd = rext;
    end else begin
      checkOutput("no_req", 32'(bus.bus_req), 32'd0);
      exp_rd = 32'd0;
    end
    @(posedge clk); #1;
    checkOutput("dv_pulse", 32'(DataValid), 32'd1);
    checkOutput("rd_data", RdData, exp_rd);
    checkOutput("misalign", 32'(MisAlign), 32'(exp_mis));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("dv_single", 32'(DataValid), 32'd0);
      checkOutput("no_rereq", 32'(bus.bus_req), 32'd0);
    end
    @(negedge clk);
    ReadReq = 1'b0;
    WenMem  = 1'b0;
    @(posedge clk); #1;
    checkOutput("dv_low", 32'(DataValid), 32'd0);
    checkOutput("misalign_clr", 32'(MisAlign), 32'd0);
  endtask

  initial begin
    logic [2:0] strb_tab [8];
    strb_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};

    reset         = 1'b1;
    ReadReq       = 1'b0;
    WenMem        = 1'b0;
    MemStrb       = 3'b010;
    Addr          = 32'd0;
    WrData        = 32'd0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'd0;
    exp_rd        = 32'd0;

    #12;
    checkOutput("rst_rddata", RdData, 32'd0);
    checkOutput("rst_dv", 32'(DataValid), 32'd0);
    checkOutput("rst_misalign", 32'(MisAlign), 32'd0);
    checkOutput("rst_req", 32'(bus.bus_req), 32'd0);
    checkOutput("rst_we", 32'(bus.bus_we), 32'd0);
    checkOutput("rst_addr", bus.bus_addr, 32'd0);
    checkOutput("rst_be", 32'(bus.bus_be), 32'd0);
    checkOutput("rst_wdata", bus.bus_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
    checkOutput("lw_value", RdData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 1, 0);
    checkOutput("lb_value", RdData, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 0, 1);
    checkOutput("lbu_value", RdData, 32'h0000_0080);
    applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0);
    checkOutput("sh_rd_keep", RdData, 32'h0000_0080);
    applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1357_9BDF, 5, 3);
    applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'hCAFE_F00D, 0, 0);
    applyStimulus(1'b0, 3'b101, 32'h0000_0011, 32'd0, 32'hA5B6_C7D8, 2, 0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0500, 32'd0, 32'h1111_1111, 0, 1);

    $display("[TB] ack outside REQ");
    @(negedge clk);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.bus_ack   = 1'b0;
    @(posedge clk); #1;
    checkOutput("stray_ack_dv", 32'(DataValid), 32'd0);
    checkOutput("stray_ack_rd", RdData, exp_rd);

    $display("[TB] reset during REQ");
    @(negedge clk);
    ReadReq = 1'b1;
    MemStrb = 3'b010;
    Addr    = 32'h0000_0300;
    @(posedge clk); #1;
    checkOutput("pre_rst_req", 32'(bus.bus_req), 32'd1);
    @(posedge clk); #2;
    reset   = 1'b1;
    ReadReq = 1'b0;
    #1;
    checkOutput("rst_async_req", 32'(bus.bus_req), 32'd0);
    exp_rd = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_no_dv", 32'(DataValid), 32'd0);
    end
    applyStimulus(1'b0, 3'b010, 32'h0000_0304, 32'd0, 32'h0BAD_F00D, 0, 0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 24; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), strb_tab[$urandom_range(0, 7)], $urandom,
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
